parity_mod_unit: RTL and testbench



---
 rtl/parity_mod_pkg.sv | 15 +
 rtl/mod_restore_step.sv | 20 ++
 rtl/parity_mod_unit.sv | 116 +++++++++++
 tb/tb_parity_mod_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_mod_pkg.sv
// Shared types and helpers for the parity-gated sequential modulo unit.
package parity_mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } pm_state_t;

    // Counter wide enough to hold values 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mod_restore_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits.
module mod_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   rem_o
);

    logic [WIDTH:0] shifted;
    logic           fits;

    assign shifted = {rem_i[WIDTH-1:0], dvd_msb_i};
    // rem_i[WIDTH] is always 0 in operation; including it keeps the compare exact.
    assign fits    = {rem_i, dvd_msb_i} >= {2'b00, b_i};
    assign rem_o   = fits ? (shifted - {1'b0, b_i}) : shifted;

endmodule

// File: rtl/parity_mod_unit.sv
// Handshaked, multi-cycle a % b, computed only when the parity of a matches
// PARITY_ODD; otherwise the result is 0. b == 0 returns a with dz set.
module parity_mod_unit
    import parity_mod_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit PARITY_ODD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             dz
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    pm_state_t        state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   rem_next;
    logic             gate_pass;

    mod_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .dvd_msb_i(dvd_q[WIDTH-1]),
        .b_i      (b_q),
        .rem_o    (rem_next)
    );

    assign gate_pass = ((^a) == PARITY_ODD);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign dz        = dz_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        c_d     = c_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    b_d = b;
                    if (!gate_pass) begin
                        c_d     = '0;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end else if (b == '0) begin
                        c_d     = a;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        dvd_d   = a;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    c_d     = rem_next[WIDTH-1:0];
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            c_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_parity_mod_unit.sv
// Scoreboard bench: three configurations (W4 odd, W4 even, W8 odd) driven one
// at a time; a negedge monitor pops expected results as they appear.
module tb_parity_mod_unit;

    typedef struct {
        int         id;
        logic [7:0] c;
        logic       dz;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] iv;
    logic [7:0] a_s, b_s;
    logic       out_ready;
    logic [2:0] ir, ov, dzv;
    logic [3:0] c0, c1;
    logic [7:0] c2;
    logic [7:0] cw [3];

    exp_t q[$];
    bit   seen [3];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parity_mod_unit #(.WIDTH(4), .PARITY_ODD(1'b1)) u_o4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[3:0]), .b(b_s[3:0]), .out_valid(ov[0]), .out_ready(out_ready),
        .c(c0), .dz(dzv[0])
    );
    parity_mod_unit #(.WIDTH(4), .PARITY_ODD(1'b0)) u_e4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[3:0]), .b(b_s[3:0]), .out_valid(ov[1]), .out_ready(out_ready),
        .c(c1), .dz(dzv[1])
    );
    parity_mod_unit #(.WIDTH(8), .PARITY_ODD(1'b1)) u_o8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s), .b(b_s), .out_valid(ov[2]), .out_ready(out_ready),
        .c(c2), .dz(dzv[2])
    );

    assign cw[0] = {4'h0, c0};
    assign cw[1] = {4'h0, c1};
    assign cw[2] = c2;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: first out_valid of each result is matched against the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && ov[i] && !seen[i]) begin
                seen[i] = 1'b1;
                n_cmp++;
                if (q.size() == 0 || q[0].id != i) begin
                    n_err++;
                    $display("FAIL spurious_out_valid: dut %0d c=%0d dz=%0d with nothing expected", i, cw[i], dzv[i]);
                end else begin
                    if (cw[i] != q[0].c || dzv[i] != q[0].dz || cyc != q[0].due) begin
                        n_err++;
                        $display("FAIL result dut%0d: got c=%0d dz=%0d at cycle %0d, required c=%0d dz=%0d at cycle %0d",
                                 i, cw[i], dzv[i], cyc, q[0].c, q[0].dz, q[0].due);
                    end else begin
                        $display("dut%0d result c=%0d dz=%0d at cycle %0d", i, cw[i], dzv[i], cyc);
                    end
                    void'(q.pop_front());
                end
            end
            if (ov[i] && out_ready) seen[i] = 1'b0;
        end
    end

    // Present one operand pair; lat = cycles from accept to out_valid.
    task automatic issue(input int id, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ec, input logic edz, input int lat);
        exp_t e;
        iv[id] = 1'b1;
        a_s    = av;
        b_s    = bv;
        check($sformatf("in_ready_before_accept_dut%0d", id), int'(ir[id]), 1);
        @(posedge clk);
        #1;
        iv[id] = 1'b0;
        e.id = id; e.c = ec; e.dz = edz; e.due = cyc + lat;
        q.push_back(e);
        $display("dut%0d issue a=%0d b=%0d expect c=%0d dz=%0d at cycle %0d", id, av, bv, ec, edz, e.due);
        if (lat > 0) begin
            check($sformatf("busy_in_ready_dut%0d", id), int'(ir[id]), 0);
            check($sformatf("busy_out_valid_dut%0d", id), int'(ov[id]), 0);
        end
    endtask

    task automatic wait_done(input int id);
        int n;
        n = 0;
        while (!(q.size() == 0 && ir[id]) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_dut%0d: result not completed within 40 cycles", id);
            q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; iv = '0; a_s = '0; b_s = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_in_ready_dut%0d", i), int'(ir[i]), 1);
            check($sformatf("reset_out_valid_dut%0d", i), int'(ov[i]), 0);
            check($sformatf("reset_c_dut%0d", i), int'(cw[i]), 0);
            check($sformatf("reset_dz_dut%0d", i), int'(dzv[i]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // W4, odd parity gate
        issue(0, 8'd7,  8'd3,  8'd1,  1'b0, 4); wait_done(0);
        issue(0, 8'd3,  8'd2,  8'd0,  1'b0, 0); wait_done(0);
        issue(0, 8'd7,  8'd0,  8'd7,  1'b1, 0); wait_done(0);
        issue(0, 8'd1,  8'd9,  8'd1,  1'b0, 4); wait_done(0);
        issue(0, 8'd14, 8'd15, 8'd14, 1'b0, 4); wait_done(0);
        issue(0, 8'd15, 8'd2,  8'd0,  1'b0, 0); wait_done(0);
        issue(0, 8'd11, 8'd1,  8'd0,  1'b0, 4); wait_done(0);
        // W4, even parity gate
        issue(1, 8'd3,  8'd2,  8'd1,  1'b0, 4); wait_done(1);
        issue(1, 8'd7,  8'd3,  8'd0,  1'b0, 0); wait_done(1);
        // W8, odd parity gate
        issue(2, 8'hFE, 8'h0D, 8'h07, 1'b0, 8); wait_done(2);
        issue(2, 8'hFF, 8'h0D, 8'h00, 1'b0, 0); wait_done(2);
        issue(2, 8'hC8, 8'h0F, 8'h05, 1'b0, 8); wait_done(2);

        // Backpressure: result held while inputs churn
        out_ready = 1'b0;
        issue(0, 8'd7, 8'd3, 8'd1, 1'b0, 4);
        begin
            int n;
            n = 0;
            while (!ov[0] && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            iv[0] = ~iv[0];
            a_s   = 8'(k * 5 + 2);
            b_s   = 8'(k + 1);
            @(posedge clk);
            #1;
            check("hold_out_valid", int'(ov[0]), 1);
            check("hold_in_ready", int'(ir[0]), 0);
            check("hold_c", int'(cw[0]), 1);
            check("hold_dz", int'(dzv[0]), 0);
        end
        iv[0] = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", int'(ir[0]), 1);
        check("release_out_valid", int'(ov[0]), 0);
        wait_done(0);

        // Reset during CALC aborts the operation
        issue(0, 8'd7, 8'd3, 8'd1, 1'b0, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_c", int'(cw[0]), 0);
        check("abort_out_valid", int'(ov[0]), 0);
        check("abort_in_ready", int'(ir[0]), 1);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_abort_out_valid", int'(ov[0]), 0);
        issue(0, 8'd13, 8'd4, 8'd1, 1'b0, 4); wait_done(0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
